// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller for the RV32I 5-stage pipeline.
// Combines the EX branch redirect, the load-use hazard and the data-memory
// ready handshake into per-stage enables and flushes. A three-state FSM
// (RUN / MEM_WAIT / ERROR) freezes the pipeline while a data access is
// outstanding and traps when the memory never answers.
// Optional build macro: PIPE_HAZARD_PERF_CNT_EN adds stall and flush
// performance counters (Stall_cycles_o, Flush_count_o).
module pipe_hazard_ctrl #(
    parameter int MAX_WAIT   = 16,
    parameter int WAIT_CNT_W = 5
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [4:0]  ID_RS1addr_i,
    input  logic [4:0]  ID_RS2addr_i,
    input  logic        ID_UseRS1_i,
    input  logic        ID_UseRS2_i,
    input  logic        EX_MemRead_i,
    input  logic [4:0]  EX_RDaddr_i,
    input  logic        EX_BranchTaken_i,
    input  logic        MEM_MemAccess_i,
    input  logic        DMEM_ready_i,
    output logic        DMEM_req_o,
    output logic        PC_en_o,
    output logic        IF_ID_en_o,
    output logic        IF_ID_flush_o,
    output logic        ID_EX_en_o,
    output logic        ID_EX_flush_o,
    output logic        EX_MEM_en_o,
    output logic        MEM_WB_bubble_o,
`ifdef PIPE_HAZARD_PERF_CNT_EN
    output logic [31:0] Stall_cycles_o,
    output logic [31:0] Flush_count_o,
`endif
    output logic        Error_o
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MAX_WAIT);
    localparam logic [WAIT_CNT_W-1:0] WAIT_ONE   = WAIT_CNT_W'(1);

    state_t                  state_reg;
    state_t                  state_next;
    logic [WAIT_CNT_W-1:0]   wait_cnt_reg;
    logic [WAIT_CNT_W-1:0]   wait_cnt_next;

    logic load_use;
    logic mem_stall;

    // Load-use hazard: a load in EX writes a register the ID instruction reads.
    always_comb begin
        load_use = EX_MemRead_i && (EX_RDaddr_i != 5'd0) &&
                   ((ID_UseRS1_i && (ID_RS1addr_i == EX_RDaddr_i)) ||
                    (ID_UseRS2_i && (ID_RS2addr_i == EX_RDaddr_i)));
    end

    // Next-state logic and all pipeline controls, in priority order:
    // error, memory freeze, branch redirect, load-use, normal flow.
    always_comb begin
        state_next      = state_reg;
        wait_cnt_next   = wait_cnt_reg;
        mem_stall       = 1'b0;
        DMEM_req_o      = 1'b0;
        PC_en_o         = 1'b1;
        IF_ID_en_o      = 1'b1;
        IF_ID_flush_o   = 1'b0;
        ID_EX_en_o      = 1'b1;
        ID_EX_flush_o   = 1'b0;
        EX_MEM_en_o     = 1'b1;
        MEM_WB_bubble_o = 1'b0;
        Error_o         = 1'b0;

        case (state_reg)
            ST_RUN: begin
                DMEM_req_o = MEM_MemAccess_i;
                if (MEM_MemAccess_i && !DMEM_ready_i) begin
                    mem_stall     = 1'b1;
                    state_next    = ST_MEM_WAIT;
                    wait_cnt_next = WAIT_ONE;
                end
            end
            ST_MEM_WAIT: begin
                // Request stays up for the whole access, including the ready cycle.
                DMEM_req_o = 1'b1;
                if (DMEM_ready_i) begin
                    state_next    = ST_RUN;
                    wait_cnt_next = '0;
                end else begin
                    mem_stall = 1'b1;
                    if (wait_cnt_reg == WAIT_LIMIT) begin
                        state_next = ST_ERROR;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + WAIT_ONE;
                    end
                end
            end
            default: begin
                state_next = ST_ERROR;
            end
        endcase

        if (state_reg == ST_ERROR) begin
            // Trapped: everything frozen, no memory traffic, until reset.
            DMEM_req_o      = 1'b0;
            PC_en_o         = 1'b0;
            IF_ID_en_o      = 1'b0;
            ID_EX_en_o      = 1'b0;
            EX_MEM_en_o     = 1'b0;
            MEM_WB_bubble_o = 1'b1;
            Error_o         = 1'b1;
        end else if (mem_stall) begin
            // Frozen stages hold branch/load-use inputs stable, so those are
            // simply re-evaluated once the access completes.
            PC_en_o         = 1'b0;
            IF_ID_en_o      = 1'b0;
            ID_EX_en_o      = 1'b0;
            EX_MEM_en_o     = 1'b0;
            MEM_WB_bubble_o = 1'b1;
        end else if (EX_BranchTaken_i) begin
            // Wrong-path IF and ID instructions are squashed; this also
            // overrides any load-use hazard seen by the wrong-path ID slot.
            IF_ID_flush_o = 1'b1;
            ID_EX_flush_o = 1'b1;
        end else if (load_use) begin
            // Hold PC and IF_ID one cycle and push a bubble into EX.
            PC_en_o       = 1'b0;
            IF_ID_en_o    = 1'b0;
            ID_EX_flush_o = 1'b1;
        end
    end

    // State and wait-counter registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg    <= ST_RUN;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

`ifdef PIPE_HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_reg;
    logic [31:0] flush_count_reg;

    // Performance counters: PC-stalled cycles outside ERROR, and IF_ID flushes.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_cycles_reg <= '0;
            flush_count_reg  <= '0;
        end else begin
            if (!PC_en_o && (state_reg != ST_ERROR)) begin
                stall_cycles_reg <= stall_cycles_reg + 32'd1;
            end
            if (IF_ID_flush_o) begin
                flush_count_reg <= flush_count_reg + 32'd1;
            end
        end
    end

    assign Stall_cycles_o = stall_cycles_reg;
    assign Flush_count_o  = flush_count_reg;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: table vectors, hand-written multi-cycle sequences and
// a randomized run against a behavioural model of the hazard controller.
module tb_pipe_hazard_ctrl;

    localparam int MAX_WAIT = 16;

    // Output word: {req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
    //               ex_mem_en, mem_wb_bubble, error}
    localparam logic [8:0] O_NORM     = 9'b011010100;
    localparam logic [8:0] O_NORM_REQ = 9'b111010100;
    localparam logic [8:0] O_LU       = 9'b000011100;
    localparam logic [8:0] O_LU_REQ   = 9'b100011100;
    localparam logic [8:0] O_BR       = 9'b011111100;
    localparam logic [8:0] O_BR_REQ   = 9'b111111100;
    localparam logic [8:0] O_STALL    = 9'b100000010;
    localparam logic [8:0] O_ERR      = 9'b000000011;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic       memrd;
        logic [4:0] rd;
        logic       br;
        logic       macc;
        logic       rdy;
    } in_t;

    typedef struct {
        in_t        in;
        logic [8:0] exp;
        string      name;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [4:0]  ID_RS1addr_i = '0;
    logic [4:0]  ID_RS2addr_i = '0;
    logic        ID_UseRS1_i = 1'b0;
    logic        ID_UseRS2_i = 1'b0;
    logic        EX_MemRead_i = 1'b0;
    logic [4:0]  EX_RDaddr_i = '0;
    logic        EX_BranchTaken_i = 1'b0;
    logic        MEM_MemAccess_i = 1'b0;
    logic        DMEM_ready_i = 1'b0;
    logic        DMEM_req_o, PC_en_o, IF_ID_en_o, IF_ID_flush_o, ID_EX_en_o;
    logic        ID_EX_flush_o, EX_MEM_en_o, MEM_WB_bubble_o, Error_o;
`ifdef PIPE_HAZARD_PERF_CNT_EN
    logic [31:0] Stall_cycles_o, Flush_count_o;
`endif

    logic [8:0] outs;
    assign outs = {DMEM_req_o, PC_en_o, IF_ID_en_o, IF_ID_flush_o, ID_EX_en_o,
                   ID_EX_flush_o, EX_MEM_en_o, MEM_WB_bubble_o, Error_o};

    int checks = 0;
    int errors = 0;

    // Reference model state: error flag, count of consecutive stalled cycles.
    bit          m_err;
    int          m_stalled;
    logic [31:0] m_stall_cnt;
    logic [31:0] m_flush_cnt;

    always #5 CLK = ~CLK;

    pipe_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .WAIT_CNT_W(5)) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .ID_RS1addr_i     (ID_RS1addr_i),
        .ID_RS2addr_i     (ID_RS2addr_i),
        .ID_UseRS1_i      (ID_UseRS1_i),
        .ID_UseRS2_i      (ID_UseRS2_i),
        .EX_MemRead_i     (EX_MemRead_i),
        .EX_RDaddr_i      (EX_RDaddr_i),
        .EX_BranchTaken_i (EX_BranchTaken_i),
        .MEM_MemAccess_i  (MEM_MemAccess_i),
        .DMEM_ready_i     (DMEM_ready_i),
        .DMEM_req_o       (DMEM_req_o),
        .PC_en_o          (PC_en_o),
        .IF_ID_en_o       (IF_ID_en_o),
        .IF_ID_flush_o    (IF_ID_flush_o),
        .ID_EX_en_o       (ID_EX_en_o),
        .ID_EX_flush_o    (ID_EX_flush_o),
        .EX_MEM_en_o      (EX_MEM_en_o),
        .MEM_WB_bubble_o  (MEM_WB_bubble_o),
`ifdef PIPE_HAZARD_PERF_CNT_EN
        .Stall_cycles_o   (Stall_cycles_o),
        .Flush_count_o    (Flush_count_o),
`endif
        .Error_o          (Error_o)
    );

    function automatic in_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic use1, input logic use2,
                               input logic memrd, input logic [4:0] rd,
                               input logic br, input logic macc, input logic rdy);
        in_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.use1 = use1; v.use2 = use2;
        v.memrd = memrd; v.rd = rd; v.br = br; v.macc = macc; v.rdy = rdy;
        return v;
    endfunction

    // Apply one cycle of inputs at the falling edge; outputs settle 1 time unit later.
    task automatic drive(input in_t v, input logic rst);
        @(negedge CLK);
        ID_RS1addr_i     = v.rs1;
        ID_RS2addr_i     = v.rs2;
        ID_UseRS1_i      = v.use1;
        ID_UseRS2_i      = v.use2;
        EX_MemRead_i     = v.memrd;
        EX_RDaddr_i      = v.rd;
        EX_BranchTaken_i = v.br;
        MEM_MemAccess_i  = v.macc;
        DMEM_ready_i     = v.rdy;
        RESET            = rst;
        #1;
    endtask

    task automatic check(input string name, input logic [8:0] exp);
        checks++;
        if (outs !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, outs, exp);
        end else begin
            $display("txn %-14s out=%b", name, outs);
        end
    endtask

    // Expected controls from the rules: trapped, frozen on an outstanding
    // access, or else branch > load-use > normal with req while accessing.
    function automatic logic [8:0] model_out(input in_t v);
        bit hazard;
        bit req;
        if (m_err) return O_ERR;
        if (!v.rdy && (m_stalled > 0 || v.macc)) return O_STALL;
        req = (m_stalled > 0) || v.macc;
        hazard = v.memrd && v.rd != 0 &&
                 ((v.use1 && v.rs1 == v.rd) || (v.use2 && v.rs2 == v.rd));
        if (v.br) return req ? O_BR_REQ : O_BR;
        if (hazard) return req ? O_LU_REQ : O_LU;
        return req ? O_NORM_REQ : O_NORM;
    endfunction

    task automatic model_advance(input in_t v, input logic rst, input logic [8:0] o);
        if (rst) begin
            m_err = 0; m_stalled = 0; m_stall_cnt = '0; m_flush_cnt = '0;
            return;
        end
        if (!o[7] && !m_err) m_stall_cnt = m_stall_cnt + 32'd1;
        if (o[5]) m_flush_cnt = m_flush_cnt + 32'd1;
        if (m_err) return;
        if (o == O_STALL) begin
            // The (MAX_WAIT+1)-th consecutive stalled cycle leads to the trap.
            m_stalled++;
            if (m_stalled == MAX_WAIT + 1) m_err = 1;
        end else begin
            m_stalled = 0;
        end
    endtask

    vec_t  vecs [12];
    in_t   idle;
    in_t   v;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[0]  = '{mk(1, 2, 1, 1, 0, 0, 0, 0, 0),  O_NORM,     "idle"};
        vecs[1]  = '{mk(5, 2, 1, 1, 1, 5, 0, 0, 0),  O_LU,       "lu_rs1"};
        vecs[2]  = '{mk(3, 7, 1, 1, 1, 7, 0, 0, 0),  O_LU,       "lu_rs2"};
        vecs[3]  = '{mk(0, 2, 1, 1, 1, 0, 0, 0, 0),  O_NORM,     "lu_x0"};
        vecs[4]  = '{mk(5, 2, 0, 1, 1, 5, 0, 0, 0),  O_NORM,     "lu_nouse1"};
        vecs[5]  = '{mk(3, 7, 1, 0, 1, 7, 0, 0, 0),  O_NORM,     "lu_nouse2"};
        vecs[6]  = '{mk(5, 2, 1, 1, 0, 5, 0, 0, 0),  O_NORM,     "no_load"};
        vecs[7]  = '{mk(1, 2, 1, 1, 0, 0, 1, 0, 0),  O_BR,       "branch"};
        vecs[8]  = '{mk(5, 2, 1, 1, 1, 5, 1, 0, 0),  O_BR,       "branch_lu"};
        vecs[9]  = '{mk(1, 2, 1, 1, 0, 0, 0, 1, 1),  O_NORM_REQ, "zero_wait"};
        vecs[10] = '{mk(1, 2, 1, 1, 0, 0, 1, 1, 1),  O_BR_REQ,   "zw_branch"};
        vecs[11] = '{mk(9, 9, 1, 1, 1, 9, 0, 1, 1),  O_LU_REQ,   "zw_lu"};

        drive(idle, 1'b1);
        drive(idle, 1'b1);
        drive(idle, 1'b0);
        check("reset_state", O_NORM);

        foreach (vecs[i]) begin
            drive(vecs[i].in, 1'b0);
            check(vecs[i].name, vecs[i].exp);
        end

        // Load-use inserts exactly one bubble: next cycle the load is in MEM.
        drive(mk(5, 0, 1, 0, 1, 5, 0, 0, 0), 1'b0);
        check("lu_bubble", O_LU);
        drive(mk(5, 0, 1, 0, 0, 0, 0, 1, 1), 1'b0);
        check("lu_release", O_NORM_REQ);

        // Three wait cycles, then ready.
        for (int i = 0; i < 3; i++) begin
            drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b0);
            check("wait3_stall", O_STALL);
        end
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 1), 1'b0);
        check("wait3_ready", O_NORM_REQ);
        drive(idle, 1'b0);
        check("wait3_after", O_NORM);

        // Branch during the wait is held off until the ready cycle.
        for (int i = 0; i < 3; i++) begin
            drive(mk(0, 0, 0, 0, 0, 0, 1, 1, 0), 1'b0);
            check("wait_br_stall", O_STALL);
        end
        drive(mk(0, 0, 0, 0, 0, 0, 1, 1, 1), 1'b0);
        check("wait_br_ready", O_BR_REQ);

        // Reset in the middle of a wait returns to RUN; request drops next cycle.
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b0);
        check("rst_wait_a", O_STALL);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b0);
        check("rst_wait_b", O_STALL);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b1);
        check("rst_wait_rst", O_STALL);
        drive(idle, 1'b0);
        check("rst_wait_after", O_NORM);

        // Timeout: 17 stalled cycles, then ERROR until reset.
        for (int i = 0; i < MAX_WAIT + 1; i++) begin
            drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b0);
            check($sformatf("tmo_stall%0d", i), O_STALL);
        end
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b0);
        check("tmo_error", O_ERR);
        drive(mk(0, 0, 0, 0, 0, 0, 1, 1, 1), 1'b0);
        check("tmo_sticky", O_ERR);
        drive(idle, 1'b1);
        check("tmo_rst", O_ERR);
        drive(idle, 1'b0);
        check("tmo_recovered", O_NORM);

        // Randomized run against the reference model.
        drive(idle, 1'b1);
        m_err = 0; m_stalled = 0; m_stall_cnt = '0; m_flush_cnt = '0;
        begin
            int   hang = 0;
            logic rst;
            logic [8:0] e;
            for (int c = 0; c < 1500; c++) begin
                if (hang == 0 && $urandom_range(0, 149) == 0) hang = 20;
                v = mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       1'($urandom), 1'($urandom), 1'($urandom),
                       5'($urandom_range(0, 3)),
                       1'($urandom_range(0, 3) == 0), 1'($urandom),
                       (hang > 0) ? 1'b0 : 1'($urandom_range(0, 2) != 0));
                if (hang > 0) hang--;
                rst = ($urandom_range(0, 99) == 0);
                drive(v, rst);
                e = model_out(v);
                check($sformatf("rand%0d", c), e);
`ifdef PIPE_HAZARD_PERF_CNT_EN
                checks++;
                if (Stall_cycles_o !== m_stall_cnt || Flush_count_o !== m_flush_cnt) begin
                    errors++;
                    $display("FAIL perf%0d: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                             c, Stall_cycles_o, Flush_count_o, m_stall_cnt, m_flush_cnt);
                end
`endif
                model_advance(v, rst, e);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
